// File: rtl/os_xor_accum_if.sv
// Handshake bundle between the OS_XOR2 parity stage, the frame accumulator
// and the syndrome consumer.
interface os_xor_accum_if #(
  parameter int W     = 7,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_acc;
  logic [CNT_W-1:0] out_cnt;
  logic             out_par;

  modport master (
    output in_valid, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_par
  );

  modport slave (
    input  in_valid, in_y, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_par
  );
endinterface

// File: rtl/os_xor_accum.sv
// XOR-folds parity slices into a per-frame syndrome; a frame closes after
// FRAME_LEN beats or on in_last, and the result is held until taken.
module os_xor_accum #(
  parameter int W         = 7,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input logic          clk,
  input logic          rst,
  os_xor_accum_if.slave bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACC  = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  localparam logic [CNT_W-1:0] LEN = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       st;
  logic [1:0]       st_nxt;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             take;
  logic             first_close;

  always_comb begin
    bus.out_valid = (st == HOLD);
    bus.in_ready  = (st == HOLD) ? bus.out_ready : 1'b1;
    bus.out_acc   = acc;
    bus.out_cnt   = cnt;
    bus.out_par   = ^acc;
  end

  assign accept      = bus.in_valid & bus.in_ready;
  assign take        = bus.out_valid & bus.out_ready;
  assign cnt_inc     = cnt + ONE;
  assign first_close = bus.in_last | (FRAME_LEN == 1);

  always_comb begin
    st_nxt  = st;
    acc_nxt = acc;
    cnt_nxt = cnt;
    case (st)
      IDLE: begin
        if (accept) begin
          acc_nxt = bus.in_y;
          cnt_nxt = ONE;
          st_nxt  = first_close ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_nxt = acc ^ bus.in_y;
          cnt_nxt = cnt_inc;
          st_nxt  = (bus.in_last || cnt_inc == LEN) ? HOLD : ACC;
        end
      end
      HOLD: begin
        // A beat can only slip in alongside the result handshake, and then
        // it opens the next frame exactly as it would from IDLE.
        if (take) begin
          if (accept) begin
            acc_nxt = bus.in_y;
            cnt_nxt = ONE;
            st_nxt  = first_close ? HOLD : ACC;
          end else begin
            acc_nxt = '0;
            cnt_nxt = '0;
            st_nxt  = IDLE;
          end
        end
      end
      default: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        st_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule
